// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment counter display.
// Segment patterns are {a,b,c,d,e,f,g,dp}, active-high.
package seg_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam logic [7:0] SEG_BLANK  = 8'h00;
   localparam logic [7:0] SEG_0      = 8'hFC;
   localparam logic [7:0] SEG_1      = 8'h60;
   localparam logic [7:0] SEG_2      = 8'hDA;
   localparam logic [7:0] SEG_3      = 8'hF2;
   localparam logic [7:0] SEG_4      = 8'h66;
   localparam logic [7:0] SEG_5      = 8'hB6;
   localparam logic [7:0] SEG_6      = 8'hBE;
   localparam logic [7:0] SEG_7      = 8'hE0;
   localparam logic [7:0] SEG_8      = 8'hFE;
   localparam logic [7:0] SEG_9      = 8'hF6;

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD digit to 7-segment pattern decoder; non-BCD codes go dark.
module bcd7seg
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   // Digit lookup, decimal point always off.
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_array_display.sv
// Button-press counter: synchronised/debounced btn edges increment an 8-digit
// BCD count that is scanned onto a multiplexed 7-segment array.
module seg_array_display
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 100_000,
   parameter int DEBOUNCE = 0
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   output logic [7:0] seg_data,
   output logic [7:0] seg_sel
);

   localparam int CW = NUM_DIGITS * 4;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic                  btn_meta_r, btn_sync_r, btn_prev_r;
   logic                  btn_clean_s, btn_pulse_s;
   logic [CW-1:0]         count_r;
   logic [DIV_W-1:0]      div_r;
   logic [2:0]            idx_r;
   logic [NUM_DIGITS-1:0] show_s;
   logic                  nz_s;
   logic [3:0]            cur_digit_s;
   logic [7:0]            cur_seg_s;
   logic [7:0]            seg_data_r, seg_sel_r;

   // Ripple-carry +1 across all BCD nibbles; full carry-out wraps to zero.
   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic       carry;
      logic [3:0] d;
      bcd_inc = v;
      carry   = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = v[i*4 +: 4];
         if (carry) begin
            if (d >= 4'd9) begin
               bcd_inc[i*4 +: 4] = 4'd0;
            end else begin
               bcd_inc[i*4 +: 4] = d + 4'd1;
               carry = 1'b0;
            end
         end else begin
            bcd_inc[i*4 +: 4] = d;
         end
      end
   endfunction

   // Two-flop synchroniser for the asynchronous button.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_meta_r <= 1'b0;
         btn_sync_r <= 1'b0;
      end else begin
         btn_meta_r <= btn;
         btn_sync_r <= btn_meta_r;
      end
   end

   generate
      if (DEBOUNCE == 0) begin : g_no_filter
         assign btn_clean_s = btn_sync_r;
      end else begin : g_filter
         localparam int DB_W = $clog2(DEBOUNCE + 1);
         logic [DB_W-1:0] db_cnt_r;
         logic            btn_filt_r;

         // Accept a new level only after it has held for DEBOUNCE cycles.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               db_cnt_r   <= '0;
               btn_filt_r <= 1'b0;
            end else if (btn_sync_r == btn_filt_r) begin
               db_cnt_r   <= '0;
            end else if (db_cnt_r == DB_W'(DEBOUNCE - 1)) begin
               db_cnt_r   <= '0;
               btn_filt_r <= btn_sync_r;
            end else begin
               db_cnt_r   <= db_cnt_r + 1'b1;
            end
         end
         assign btn_clean_s = btn_filt_r;
      end
   endgenerate

   assign btn_pulse_s = btn_clean_s & ~btn_prev_r;

   // Edge register and BCD count; increments in the cycle of the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_prev_r <= 1'b0;
         count_r    <= '0;
      end else begin
         btn_prev_r <= btn_clean_s;
         if (btn_pulse_s) begin
            count_r <= bcd_inc(count_r);
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Scan divider and digit index; index moves on the divider terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_r <= '0;
         idx_r <= 3'd0;
      end else if (div_r == DIV_LAST) begin
         div_r <= '0;
         idx_r <= idx_r + 3'd1;
      end else begin
         div_r <= div_r + 1'b1;
      end
   end

   // Leading-zero blanking: a digit shows if it or any higher digit is non-zero.
   always_comb begin
      nz_s   = 1'b0;
      show_s = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz_s      = nz_s | (count_r[i*4 +: 4] != 4'd0);
         show_s[i] = nz_s;
      end
      show_s[0] = 1'b1;
   end

   assign cur_digit_s = count_r[{idx_r, 2'b00} +: 4];

   bcd7seg u_dec (
      .bcd (cur_digit_s),
      .seg (cur_seg_s)
   );

   // Registered pin drivers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_data_r <= SEG_BLANK;
         seg_sel_r  <= 8'hFF;
      end else begin
         seg_sel_r  <= ~(8'b0000_0001 << idx_r);
         seg_data_r <= show_s[idx_r] ? cur_seg_s : SEG_BLANK;
      end
   end

   assign seg_data = seg_data_r;
   assign seg_sel  = seg_sel_r;

endmodule

// File: tb/tb_seg_array_display.sv
// Randomised bench for seg_array_display: a decimal press-count model predicts
// every scanned digit pattern and select value.
module tb_seg_array_display;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0;
   logic [7:0] seg_data, seg_sel;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int mcount  = 0;

   logic [7:0] pat [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                            8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

   seg_array_display #(.SCAN_DIV(4), .DEBOUNCE(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn),
      .seg_data (seg_data),
      .seg_sel  (seg_sel)
   );

   always #5 clk = ~clk;

   // Edges seen since reset release; defines which slot the pins should show.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h (cyc %0d count %0d)", tag, got, exp, cyc, mcount);
      end
   endtask

   function automatic logic [7:0] exp_data(input int cnt, input int idx);
      int pw;
      pw = 1;
      for (int k = 0; k < idx; k++) pw = pw * 10;
      if (idx > 0 && cnt < pw) return 8'h00;
      return pat[(cnt / pw) % 10];
   endfunction

   function automatic logic [7:0] exp_sel(input int idx);
      logic [7:0] one;
      one = 8'b0000_0001;
      return ~(one << idx);
   endfunction

   task automatic press(input int hold, input int gap);
      @(negedge clk);
      btn = 1'b1;
      repeat (hold) @(negedge clk);
      btn = 1'b0;
      repeat (gap) @(negedge clk);
      mcount = (mcount + 1) % 100_000_000;
   endtask

   task automatic scan_check(input string tag, input int settle, input int n);
      int idx;
      repeat (settle) @(negedge clk);
      repeat (n) begin
         @(negedge clk);
         idx = ((cyc - 1) / 4) % 8;
         check({tag, "_sel"}, seg_sel, exp_sel(idx));
         check({tag, "_data"}, seg_data, exp_data(mcount, idx));
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data", seg_data, 8'h00);
      check("rst_sel", seg_sel, 8'hFF);
      rst = 1'b0;
      scan_check("zero", 0, 36);

      // Five single-cycle pulses
      repeat (5) press(1, 3);
      scan_check("five", 6, 32);

      // Long hold counts exactly once
      press(100, 3);
      scan_check("hold", 6, 32);

      // Up to 9, then the first carry
      repeat (3) press(1, 2);
      scan_check("nine", 6, 32);
      press(2, 2);
      scan_check("ten", 6, 32);

      // Up to 99, then the two-digit carry into "100"
      repeat (89) press(1, 2);
      scan_check("n99", 6, 32);
      press(1, 2);
      scan_check("n100", 6, 32);

      // Random press lengths and gaps
      repeat (6) begin
         repeat ($urandom_range(1, 25)) press($urandom_range(1, 6), $urandom_range(2, 8));
         scan_check("rand", 6, 32);
      end

      // Mid-operation reset with count at 5
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mcount = 0;
      repeat (5) press(1, 3);
      scan_check("pre_rst", 6, 8);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_data", seg_data, 8'h00);
      check("mid_rst_sel", seg_sel, 8'hFF);
      repeat (3) @(negedge clk);
      check("mid_rst_hold_data", seg_data, 8'h00);
      check("mid_rst_hold_sel", seg_sel, 8'hFF);
      rst = 1'b0;
      mcount = 0;
      scan_check("post_rst", 0, 8);
      repeat (3) press($urandom_range(1, 4), 3);
      scan_check("three", 6, 32);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
